// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Collects bytes from the CPU MMIO write path (address 16'hF001) and a debug
// byte stream into a shared FIFO, then feeds the UART transmitter one byte per
// frame through its toggle-based interface. Consecutive issues are spaced by
// FRAME_CYCLES = 10*DELAY_FRAMES + 2 clocks: start, 8 data bits and stop, plus
// 2 guard cycles.
//
// Optional feature macro: UART_SCHED_CRLF_EN
//   defined   : an LF (8'h0A) at the FIFO head is preceded by an inserted CR
//               (8'h0D). The LF stays in the FIFO until the following slot.
//   undefined : bytes pass through unmodified.
//
// state  | meaning
// IDLE   | nothing on the wire; issue as soon as the FIFO is non-empty
// WAIT   | frame in flight; counter runs down to the next issue slot

module uart_tx_scheduler #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [15:0]                  cpu_addr,
  input  logic [7:0]                   cpu_data,
  input  logic                         cpu_we,
  input  logic                         dbg_valid,
  input  logic [7:0]                   dbg_data,
  output logic                         dbg_ready,
  output logic [15:0]                  uart_addr,
  output logic [7:0]                   uart_data,
  output logic                         uart_update,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
);

  localparam int FRAME_CYCLES = 10 * DELAY_FRAMES + 2;
  localparam int CW           = $clog2(FRAME_CYCLES + 1);
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int LW           = PW + 1;

  localparam logic [15:0] ADDR_TX  = 16'hF001;
  localparam logic [15:0] ADDR_CLR = 16'hF002;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      uart_data_q;
  logic            uart_update_q;
  logic            overflow_q;
  logic            overflow_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;

  logic            full;
  logic            empty;
  logic            cpu_hit;
  logic            cpu_clr;
  logic            cpu_push;
  logic            dbg_push;
  logic            push;
  logic [7:0]      push_data;
  logic [7:0]      head;
  logic            slot;
  logic            pop;
  logic [7:0]      issue_byte;

`ifdef UART_SCHED_CRLF_EN
  logic            cr_q;
  logic            insert_cr;
`endif

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // Push arbitration: CPU has fixed priority; debug is only offered the slot
  // when the CPU is not pushing and the FIFO has room.
  always_comb begin
    cpu_hit   = cpu_we && (cpu_addr == ADDR_TX);
    cpu_clr   = cpu_we && (cpu_addr == ADDR_CLR);
    cpu_push  = cpu_hit && !full;
    dbg_ready = !full && !cpu_hit;
    dbg_push  = dbg_valid && dbg_ready;
    push      = cpu_push || dbg_push;
    push_data = cpu_hit ? cpu_data : dbg_data;
  end

  // Issue slot decode: the head is consumed unless a CR is being inserted.
  always_comb begin
    slot = ((state_q == S_IDLE) || (cnt_q == '0)) && !empty;
`ifdef UART_SCHED_CRLF_EN
    insert_cr  = slot && (head == 8'h0A) && !cr_q;
    pop        = slot && !insert_cr;
    issue_byte = insert_cr ? 8'h0D : head;
`else
    pop        = slot;
    issue_byte = head;
`endif
  end

  // Occupancy next-state: +1 push, -1 pop, unchanged for both or neither.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Overflow: a dropped CPU byte sets it; a write to the clear address
  // clears it, with set taking priority.
  always_comb begin
    overflow_d = overflow_q;
    if (cpu_clr) overflow_d = 1'b0;
    if (cpu_hit && full) overflow_d = 1'b1;
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

`ifdef UART_SCHED_CRLF_EN
  // CR flag: set when a CR is inserted, cleared when the LF itself goes out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cr_q <= 1'b0;
    else if (slot) cr_q <= insert_cr;
  end
`endif

  // Drain FSM: issue a byte, then hold off for a full frame before the next.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      uart_data_q   <= 8'h00;
      uart_update_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slot) begin
            uart_data_q   <= issue_byte;
            uart_update_q <= ~uart_update_q;
            cnt_q         <= CW'(FRAME_CYCLES - 1);
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (slot) begin
            uart_data_q   <= issue_byte;
            uart_update_q <= ~uart_update_q;
            cnt_q         <= CW'(FRAME_CYCLES - 1);
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_addr   = ADDR_TX;
  assign uart_data   = uart_data_q;
  assign uart_update = uart_update_q;
  assign busy        = (state_q == S_WAIT);
  assign fifo_level  = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with DELAY_FRAMES=4 (frame = 42
// clocks) and FIFO_DEPTH=4. Honours UART_SCHED_CRLF_EN when defined.
module tb_uart_tx_scheduler;

  localparam int DF    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DF + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_we = 1'b0;
  logic        dbg_valid = 1'b0;
  logic [7:0]  dbg_data = 8'h00;
  logic        dbg_ready;
  logic [15:0] uart_addr;
  logic [7:0]  uart_data;
  logic        uart_update;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int n;

  uart_tx_scheduler #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .uart_addr(uart_addr), .uart_data(uart_data), .uart_update(uart_update),
    .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Ticks until uart_update changes; returns the number of edges (bounded).
  task automatic wait_toggle(output int cnt);
    logic prev;
    prev = uart_update;
    cnt = 0;
    while (uart_update === prev && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  // Ticks until busy drops (bounded); returns edges spent.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
    tick();
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_addr", uart_addr, 16'hF001);
    check("rst_data", uart_data, 0);
    check("rst_update", uart_update, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();
    check("rst_dbg_ready", dbg_ready, 1);

    // Single CPU byte: push edge, issue on next edge, busy for one frame
    cpu_write(16'hF001, 8'h41);
    check("s1_level_after_push", fifo_level, 1);
    check("s1_no_toggle_yet", uart_update, 0);
    tick();
    check("s1_toggle", uart_update, 1);
    check("s1_data", uart_data, 8'h41);
    check("s1_busy_rise", busy, 1);
    check("s1_level_after_pop", fifo_level, 0);
    repeat (FRAME - 1) tick();
    check("s1_busy_last", busy, 1);
    tick();
    check("s1_busy_fall", busy, 0);

    // Backlog spacing
    cpu_write(16'hF001, 8'h01);
    cpu_write(16'hF001, 8'h02);
    check("s2_first_data", uart_data, 8'h01);
    check("s2_first_toggle", uart_update, 0);
    cpu_write(16'hF001, 8'h03);
    check("s2_level_queued", fifo_level, 2);
    wait_toggle(n);
    check("s2_spacing1", n, FRAME - 1);
    check("s2_second_data", uart_data, 8'h02);
    wait_toggle(n);
    check("s2_spacing2", n, FRAME);
    check("s2_third_data", uart_data, 8'h03);
    check("s2_level_empty", fifo_level, 0);
    wait_idle(n);
    check("s2_idle_after", n, FRAME);

    // Simultaneous requesters
    cpu_we = 1'b1; cpu_addr = 16'hF001; cpu_data = 8'hAA;
    dbg_valid = 1'b1; dbg_data = 8'h55;
    #1;
    check("s3_dbg_ready_blocked", dbg_ready, 0);
    tick();
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    #1;
    check("s3_dbg_ready_open", dbg_ready, 1);
    tick();
    dbg_valid = 1'b0;
    check("s3_first_data", uart_data, 8'hAA);
    check("s3_level", fifo_level, 1);
    wait_toggle(n);
    check("s3_spacing", n, FRAME);
    check("s3_second_data", uart_data, 8'h55);
    wait_idle(n);
    check("s3_idle", busy, 0);

    // Overflow
    cpu_write(16'hF001, 8'h10);
    cpu_write(16'hF001, 8'h11);
    check("s4_first_issue", uart_data, 8'h10);
    cpu_write(16'hF001, 8'h12);
    cpu_write(16'hF001, 8'h13);
    check("s4_no_overflow_yet", overflow, 0);
    cpu_write(16'hF001, 8'h14);
    check("s4_level_full", fifo_level, 4);
    check("s4_dbg_ready_full", dbg_ready, 0);
    cpu_write(16'hF001, 8'h15);
    check("s4_overflow_set", overflow, 1);
    check("s4_level_still_full", fifo_level, 4);
    cpu_write(16'hF002, 8'hFF);
    check("s4_overflow_clear", overflow, 0);
    wait_toggle(n);
    check("s4_d11", uart_data, 8'h11);
    wait_toggle(n);
    check("s4_d12", uart_data, 8'h12);
    wait_toggle(n);
    check("s4_d13", uart_data, 8'h13);
    wait_toggle(n);
    check("s4_d14", uart_data, 8'h14);
    check("s4_level_drained", fifo_level, 0);
    wait_idle(n);
    check("s4_idle", busy, 0);

    // LF handling
    dbg_valid = 1'b1; dbg_data = 8'h0A;
    tick();
    dbg_valid = 1'b0;
    tick();
`ifdef UART_SCHED_CRLF_EN
    check("s5_cr_first", uart_data, 8'h0D);
    check("s5_lf_held", fifo_level, 1);
    wait_toggle(n);
    check("s5_lf_spacing", n, FRAME);
    check("s5_lf_second", uart_data, 8'h0A);
    check("s5_level_empty", fifo_level, 0);
`else
    check("s5_lf_only", uart_data, 8'h0A);
    check("s5_level_empty", fifo_level, 0);
`endif
    wait_idle(n);
    check("s5_no_extra_frame", n, FRAME);

    // Reset mid-frame with two bytes queued
    cpu_write(16'hF001, 8'h21);
    cpu_write(16'hF001, 8'h22);
    cpu_write(16'hF001, 8'h23);
    check("s6_level_queued", fifo_level, 2);
    repeat (19) tick();
    reset = 1'b1;
    #1;
    check("s6_rst_update", uart_update, 0);
    check("s6_rst_data", uart_data, 0);
    check("s6_rst_busy", busy, 0);
    check("s6_rst_level", fifo_level, 0);
    check("s6_rst_addr", uart_addr, 16'hF001);
    tick();
    reset = 1'b0;
    wait_toggle(n);
    check("s6_no_toggle_after", n, 200);
    check("s6_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
